// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM for LW/SW/ADD/ADDI/BEQ with retired-instruction counter
module mips_mc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state
);
  localparam logic [3:0] S_RST     = 4'd15;
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_ILLEGAL = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADD   = 6'h20;

  logic [3:0]  state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = (opcode == OP_LW || opcode == OP_SW)        ? S_MEMADR :
                           (opcode == OP_RTYPE && funct == FN_ADD)     ? S_EXEC   :
                           (opcode == OP_BEQ)                          ? S_BRANCH :
                           (opcode == OP_ADDI)                         ? S_ADDIEX : S_ILLEGAL;
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_ILLEGAL: state_d = S_FETCH;
      default:   state_d = S_RST;
    endcase
  end

  // a store retires only on the cycle memory accepts it
  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR && mem_ready) ||
                  (state_q == S_RWB) || (state_q == S_BRANCH) || (state_q == S_ADDIWB);
  assign retired_d = retire ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_opcode = 6'h00;
    alu_funct  = 6'h00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'd1;
        alu_opcode = OP_ADDI;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'd3;
        alu_opcode = OP_ADDI;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_opcode = OP_ADDI;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_funct = FN_ADD;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_opcode = OP_BEQ;
        pc_src     = 1'b1;
        pc_write   = zero;
      end
      S_ADDIWB:  reg_write = 1'b1;
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign retired = retired_q;
  assign state   = state_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed-vector bench for the multicycle MIPS controller
module tb_mips_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [5:0]  alu_opcode, alu_funct;
  logic        reg_write, reg_dst, mem_to_reg, illegal;
  logic [31:0] retired;
  logic [3:0]  state;
  int checks = 0;
  int failures = 0;

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_opcode(alu_opcode),
    .alu_funct(alu_funct), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd15);
    chk("rst_retired", retired, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 6'h23;
    mem_ready = 1'b1;
    // LW: 15 -> 0,1,2,3,4 -> 0
    step(); chk("lw_fetch", 32'(state), 32'd0);
    chk("fetch_req", 32'({mem_req, iord, ir_write, pc_write, alu_src_a}), 32'b10110);
    chk("fetch_alu", 32'({alu_src_b, alu_opcode}), 32'({2'd1, 6'h08}));
    step(); chk("lw_decode", 32'(state), 32'd1);
    chk("decode_alu", 32'({alu_src_a, alu_src_b, alu_opcode}), 32'({1'b0, 2'd3, 6'h08}));
    step(); chk("lw_memadr", 32'(state), 32'd2);
    chk("memadr_alu", 32'({alu_src_a, alu_src_b, alu_opcode}), 32'({1'b1, 2'd2, 6'h08}));
    step(); chk("lw_memrd", 32'(state), 32'd3);
    chk("memrd_out", 32'({mem_req, mem_we, iord}), 32'b101);
    opcode = 6'h2b;
    step(); chk("lw_memwb", 32'(state), 32'd4);
    chk("memwb_out", 32'({reg_write, reg_dst, mem_to_reg}), 32'b101);
    chk("lw_not_retired_yet", retired, 32'd0);
    step(); chk("lw_back_fetch", 32'(state), 32'd0);
    chk("lw_retired", retired, 32'd1);
    // SW with three wait cycles
    step(); chk("sw_decode", 32'(state), 32'd1);
    mem_ready = 1'b0;
    step(); chk("sw_memadr", 32'(state), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sw_wait_state", 32'(state), 32'd5);
      chk("sw_wait_req", 32'({mem_req, mem_we, iord}), 32'b111);
      chk("sw_wait_retired", retired, 32'd1);
    end
    mem_ready = 1'b1;
    #1 chk("sw_last_req", 32'({mem_req, mem_we}), 32'b11);
    step(); chk("sw_done", 32'(state), 32'd0);
    chk("sw_retired", retired, 32'd2);
    // BEQ taken then not taken
    opcode = 6'h04;
    zero = 1'b1;
    step(); step(); chk("beq_t_state", 32'(state), 32'd8);
    chk("beq_t_pc", 32'({pc_write, pc_src, alu_src_a, alu_opcode}), 32'({3'b111, 6'h04}));
    step(); chk("beq_t_retired", retired, 32'd3);
    zero = 1'b0;
    step(); step(); chk("beq_nt_state", 32'(state), 32'd8);
    chk("beq_nt_pc", 32'({pc_write, pc_src}), 32'b01);
    step(); chk("beq_nt_retired", retired, 32'd4);
    // ADD: 4 cycles
    opcode = 6'h00;
    funct = 6'h20;
    step(); step(); chk("add_exec", 32'(state), 32'd6);
    chk("exec_alu", 32'({alu_src_a, alu_src_b, alu_opcode, alu_funct}), 32'({1'b1, 2'd0, 6'h00, 6'h20}));
    step(); chk("add_rwb", 32'(state), 32'd7);
    chk("rwb_out", 32'({reg_write, reg_dst, mem_to_reg}), 32'b110);
    step(); chk("add_retired", retired, 32'd5);
    // ADDI
    opcode = 6'h08;
    step(); step(); chk("addi_ex", 32'(state), 32'd9);
    chk("addiex_alu", 32'({alu_src_a, alu_src_b, alu_opcode}), 32'({1'b1, 2'd2, 6'h08}));
    step(); chk("addi_wb", 32'(state), 32'd10);
    chk("addiwb_out", 32'({reg_write, reg_dst, mem_to_reg}), 32'b100);
    step(); chk("addi_retired", retired, 32'd6);
    // unsupported funct
    opcode = 6'h00;
    funct = 6'h22;
    step(); step(); chk("ill_state", 32'(state), 32'd11);
    chk("ill_pulse", 32'(illegal), 32'd1);
    step(); chk("ill_back_fetch", 32'(state), 32'd0);
    chk("ill_pulse_end", 32'(illegal), 32'd0);
    chk("ill_retired", retired, 32'd6);
    // counter wrap: preload during a fetch wait, then two ADDs
    mem_ready = 1'b0;
    funct = 6'h20;
    step();
    force dut.retired_q = 32'hFFFF_FFFE;
    #1 release dut.retired_q;
    #1 chk("wrap_preload", retired, 32'hFFFF_FFFE);
    mem_ready = 1'b1;
    step(); step(); step(); step();
    chk("wrap_max", retired, 32'hFFFF_FFFF);
    step(); step(); step(); step();
    chk("wrap_zero", retired, 32'd0);
    chk("wrap_state", 32'(state), 32'd0);
    // async reset during fetch wait
    mem_ready = 1'b0;
    step(); step();
    chk("prerst_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_state", 32'(state), 32'd15);
    chk("arst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk("arst_fetch", 32'(state), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have ports (clock and reset first), one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  instruction bits [31:26] from instruction register
- funct  in  6  instruction bits [5:0] from instruction register
- zero  in  1  ALU zero flag; high when ALU opcode is 6'h04 and A==B
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write (SW), 0 = read
- iord  out  1  address mux: 0 = PC, 1 = ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  PC mux: 0 = ALU result, 1 = ALUOut (branch target)
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- alu_opcode  out  6  opcode driven to ALU
- alu_funct  out  6  funct driven to ALU
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register
- illegal  out  1  one-cycle pulse on unsupported instruction
- retired  out  32  count of completed instructions
- state  out  4  current FSM state
REQ-002 Parameters: none.

Function
REQ-003 FSM state encodings SHALL be: RST=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, ILLEGAL=11.
REQ-004 All outputs SHALL be combinational from state, plus mem_ready/zero where stated; any output not listed for a state SHALL be 0.
REQ-005 RST: all outputs 0; next state FETCH.
REQ-006 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_opcode=6'h08; ir_write=pc_write=mem_ready; stay until mem_ready, then DECODE.
REQ-007 DECODE: alu_src_a=0, alu_src_b=3, alu_opcode=6'h08; next by opcode: 6'h23/6'h2b->MEMADR, 6'h00 with funct 6'h20->EXEC, 6'h04->BRANCH, 6'h08->ADDIEX, else ILLEGAL.
REQ-008 MEMADR: alu_src_a=1, alu_src_b=2, alu_opcode=6'h08; next MEMRD if opcode 6'h23, else MEMWR.
REQ-009 MEMRD: mem_req=1, iord=1; wait for mem_ready, then MEMWB.
REQ-010 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-011 MEMWR: mem_req=1, mem_we=1, iord=1; wait for mem_ready, then FETCH.
REQ-012 EXEC: alu_src_a=1, alu_src_b=0, alu_opcode=6'h00, alu_funct=6'h20; next RWB.
REQ-013 RWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=0, alu_opcode=6'h04, pc_src=1, pc_write=zero; next FETCH.
REQ-015 ADDIEX: alu_src_a=1, alu_src_b=2, alu_opcode=6'h08; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-016 ILLEGAL: illegal=1 for exactly one cycle; next FETCH; retired not incremented.
REQ-017 retired SHALL increment by 1 on the clock edge leaving MEMWB, MEMWR (mem_ready=1), RWB, BRANCH (taken or not) or ADDIWB; 32'hFFFFFFFF wraps to 0.
REQ-018 mem_ready while mem_req=0 SHALL be ignored; mem_req SHALL never drop before mem_ready.
REQ-019 Latency SHALL be: LW 5 cycles, SW 4, ADD 4, ADDI 4, BEQ 3, each with zero memory wait; each wait cycle adds one.
REQ-020 opcode/funct SHALL be sampled only in DECODE/MEMADR; changes elsewhere SHALL have no effect.

Reset
REQ-021 rst_n low SHALL asynchronously force state=RST and retired=0, deasserting all outputs (including mid-request mem_req) without waiting for clk.
REQ-022 After rst_n rises, first edge SHALL enter FETCH.

Verification
REQ-023 Reset release, mem_ready=1 always, opcode 6'h23 -> states 15,0,1,2,3,4,0; reg_write & mem_to_reg in state 4; retired=1.
REQ-024 SW, mem_ready low 3 cycles in MEMWR -> mem_req=mem_we=1 held 4 cycles; retired increments only after mem_ready.
REQ-025 BEQ with zero=1 -> pc_write=1, pc_src=1 in BRANCH; with zero=0 -> pc_write=0; both increment retired.
REQ-026 opcode 6'h00, funct 6'h22 -> ILLEGAL one cycle, illegal pulse, retired unchanged, then FETCH.
REQ-027 rst_n low during FETCH wait with mem_req=1 -> mem_req=0 immediately, retired=0, state=15.
REQ-028 retired forced near 32'hFFFFFFFF via ADD stream -> wraps to 0 after next completion.
